// File: rtl/ldl_tx_if.sv
// Producer-side word handshake for the LEDR transmitter.
// The producer (master) offers in_data/in_valid; the transmitter (slave) answers with in_ready.
interface ldl_tx_if #(
    parameter int DATA_MSB = 7
);
    logic [DATA_MSB:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/ldl_tx.sv
// Clocked producer to LEDR (value/timing dual-rail) channel transmitter.
// Optional acknowledge watchdog: define LDL_TX_TIMEOUT_EN.
module ldl_tx #(
    parameter int DATA_MSB       = 7,
    parameter int DELAY          = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    ldl_tx_if.slave         in_if,
    output logic [DATA_MSB:0] ledr_v,
    output logic [DATA_MSB:0] ledr_t,
    input  logic            ledr_ack,
    output logic            phase,
    output logic            proto_err
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_phase;
    logic [DATA_MSB:0] r_v;
    logic [DATA_MSB:0] r_t;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_err;
    logic              w_take;
    logic              w_ack_ok;
    logic              w_tmo;
    logic              w_unused;

    assign w_take   = (r_state == S_IDLE) && in_if.in_valid;
    assign w_ack_ok = (r_sync2 == r_phase);

`ifdef LDL_TX_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_take) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_tmo    = (r_state == S_WAIT) && (r_cnt == TMO_LAST);
    assign w_unused = (DELAY != 0);
`else
    assign w_tmo    = 1'b0;
    assign w_unused = (DELAY != 0) ^ (TIMEOUT_CYCLES != 0);
`endif

    // Only metastability point: ledr_ack is read nowhere else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ledr_ack;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (in_if.in_valid) w_next = S_WAIT;
            S_WAIT: if (w_ack_ok || w_tmo) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_if.in_ready = 1'b0;
        if (r_state == S_IDLE) in_if.in_ready = 1'b1;
    end

    // t = v ^ new_phase, so each bit flips exactly one rail per token.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= 1'b0;
            r_v     <= '0;
            r_t     <= '0;
        end else if (w_take) begin
            r_phase <= ~r_phase;
            r_v     <= in_if.in_data;
            r_t     <= in_if.in_data ^ {(DATA_MSB+1){~r_phase}};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (((r_state == S_IDLE) && !w_ack_ok) || w_tmo) begin
            r_err <= 1'b1;
        end
    end

    assign ledr_v    = r_v;
    assign ledr_t    = r_t;
    assign phase     = r_phase;
    assign proto_err = r_err;
endmodule

// File: tb/tb_ldl_tx.sv
// Directed bench for ldl_tx: reset, single token, back-to-back,
// backpressure, spurious acknowledge and acknowledge watchdog.
module tb_ldl_tx;
    logic       clk;
    logic       reset;
    logic       ack_man;
    logic       auto_ack;
    logic       ledr_ack;
    logic [7:0] ledr_v;
    logic [7:0] ledr_t;
    logic       phase;
    logic       proto_err;
    int         total;
    int         bad;

    ldl_tx_if #(.DATA_MSB(7)) bus ();

    ldl_tx #(
        .DATA_MSB       (7),
        .DELAY          (1),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_if     (bus.slave),
        .ledr_v    (ledr_v),
        .ledr_t    (ledr_t),
        .ledr_ack  (ledr_ack),
        .phase     (phase),
        .proto_err (proto_err)
    );

    // Receiver model: either echoes phase at once or is driven by hand.
    assign ledr_ack = auto_ack ? phase : ack_man;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        auto_ack     = 1'b0;
        ack_man      = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_during got=%b want=1", bus.in_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (ledr_v !== 8'h00 || ledr_t !== 8'h00) begin
            bad++;
            $display("FAIL reset_rails got v=%h t=%h want 00/00", ledr_v, ledr_t);
        end
        total++;
        if (phase !== 1'b0 || proto_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_phase_err got ph=%b err=%b want 0/0", phase, proto_err);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_after got=%b want=1", bus.in_ready);
        end
    endtask

    task automatic test_single;
        @(negedge clk);
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (ledr_v !== 8'hA5 || ledr_t !== 8'h5A || phase !== 1'b1) begin
            bad++;
            $display("FAIL single_token got v=%h t=%h ph=%b want A5/5A/1", ledr_v, ledr_t, phase);
        end
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_ready_low got=%b want=0", bus.in_ready);
        end
        ack_man = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_ready_early got=%b want=0", bus.in_ready);
        end
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || proto_err !== 1'b0) begin
            bad++;
            $display("FAIL single_ready_back got rdy=%b err=%b want 1/0", bus.in_ready, proto_err);
        end
    endtask

    task automatic test_back_to_back;
        int         tok;
        int         c1;
        int         c2;
        logic       pph;
        logic [7:0] pv;
        logic [7:0] pt;
        reset   = 1'b0;
        ack_man = 1'b0;
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        auto_ack = 1'b1;
        @(negedge clk);
        tok = 0;
        c1  = 0;
        c2  = 0;
        pv  = 8'h00;
        pt  = 8'h00;
        pph = phase;
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        for (int c = 1; c <= 20 && tok < 2; c++) begin
            @(negedge clk);
            if (phase !== pph) begin
                tok++;
                pph = phase;
                if (tok == 1) begin
                    c1 = c;
                    total++;
                    if (ledr_v !== 8'hFF || ledr_t !== 8'h00) begin
                        bad++;
                        $display("FAIL b2b_first got v=%h t=%h want FF/00", ledr_v, ledr_t);
                    end
                    pv = ledr_v;
                    pt = ledr_t;
                    bus.in_data = 8'h00;
                end else begin
                    c2 = c;
                    bus.in_valid = 1'b0;
                    total++;
                    if (ledr_v !== 8'h00 || ledr_t !== 8'h00 || phase !== 1'b0) begin
                        bad++;
                        $display("FAIL b2b_second got v=%h t=%h ph=%b want 00/00/0", ledr_v, ledr_t, phase);
                    end
                    total++;
                    if (((pv ^ ledr_v) ^ (pt ^ ledr_t)) !== 8'hFF) begin
                        bad++;
                        $display("FAIL b2b_one_rail got v %h->%h t %h->%h", pv, ledr_v, pt, ledr_t);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        total++;
        if (tok != 2) begin
            bad++;
            $display("FAIL b2b_tokens got=%0d want=2", tok);
        end
        total++;
        if (c2 - c1 != 4) begin
            bad++;
            $display("FAIL b2b_period got=%0d want=4", c2 - c1);
        end
        repeat (4) @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || proto_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got rdy=%b err=%b want 1/0", bus.in_ready, proto_err);
        end
        ack_man  = phase;
        auto_ack = 1'b0;
    endtask

    task automatic test_backpressure;
        int diffs;
        int n;
        @(negedge clk);
        bus.in_data  = 8'h11;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_data = 8'h3C;
        total++;
        if (ledr_v !== 8'h11 || ledr_t !== 8'hEE || phase !== 1'b1) begin
            bad++;
            $display("FAIL bp_first got v=%h t=%h ph=%b want 11/EE/1", ledr_v, ledr_t, phase);
        end
        diffs = 0;
        repeat (50) begin
            @(negedge clk);
            if (ledr_v !== 8'h11 || ledr_t !== 8'hEE || phase !== 1'b1 || bus.in_ready !== 1'b0)
                diffs++;
        end
        total++;
        if (diffs != 0) begin
            bad++;
            $display("FAIL bp_hold got=%0d changed cycles want=0", diffs);
        end
        ack_man = 1'b1;
        n = 0;
        for (int c = 1; c <= 10 && n == 0; c++) begin
            @(negedge clk);
            if (phase === 1'b0) n = c;
        end
        bus.in_valid = 1'b0;
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL bp_take_latency got=%0d want=4", n);
        end
        total++;
        if (ledr_v !== 8'h3C || ledr_t !== 8'h3C) begin
            bad++;
            $display("FAIL bp_second got v=%h t=%h want 3C/3C", ledr_v, ledr_t);
        end
        ack_man = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || proto_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_idle got rdy=%b err=%b want 1/0", bus.in_ready, proto_err);
        end
    endtask

    task automatic test_spurious;
        int stuck;
        @(negedge clk);
        ack_man = 1'b1;
        @(negedge clk);
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("FAIL spur_early got=%b want=0", proto_err);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL spur_set got=%b want=1", proto_err);
        end
        ack_man = 1'b0;
        stuck = 0;
        repeat (5) begin
            @(negedge clk);
            if (proto_err !== 1'b1) stuck++;
        end
        total++;
        if (stuck != 0) begin
            bad++;
            $display("FAIL spur_sticky got=%0d cleared cycles want=0", stuck);
        end
        reset = 1'b0;
        #1;
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("FAIL spur_reset got=%b want=0", proto_err);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        @(negedge clk);
        bus.in_data  = 8'h81;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (ledr_v !== 8'h81 || ledr_t !== 8'h7E || phase !== 1'b1) begin
            bad++;
            $display("FAIL tmo_token got v=%h t=%h ph=%b want 81/7E/1", ledr_v, ledr_t, phase);
        end
`ifdef LDL_TX_TIMEOUT_EN
        repeat (9) @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0 || proto_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_early got rdy=%b err=%b want 0/0", bus.in_ready, proto_err);
        end
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || proto_err !== 1'b1) begin
            bad++;
            $display("FAIL tmo_fire got rdy=%b err=%b want 1/1", bus.in_ready, proto_err);
        end
`else
        repeat (1000) @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0 || proto_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_none got rdy=%b err=%b want 0/0", bus.in_ready, proto_err);
        end
`endif
        total++;
        if (ledr_v !== 8'h81 || ledr_t !== 8'h7E || phase !== 1'b1) begin
            bad++;
            $display("FAIL tmo_rails got v=%h t=%h ph=%b want 81/7E/1", ledr_v, ledr_t, phase);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_spurious();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
